// File: rtl/obstacle_spawner.sv
// Scrolls and spawns the two Dino-game obstacles once per game tick; freezes on crash.
// Optional `OBSTACLE_SPEEDUP_EN raises scroll speed by one every eight spawns.
module obstacle_spawner #(
  parameter int          CONV      = 0,
  parameter int          GEN_LINE  = 250,
  parameter logic [7:0]  MIN_GAP   = 8'd40,
  parameter logic [2:0]  MAX_SPEED = 3'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            game_tick,
  input  logic            start,
  input  logic            crash,
  output logic [9:CONV]   obstacle1_pos,
  output logic [9:CONV]   obstacle2_pos,
  output logic [1:0]      obstacle1_type,
  output logic [1:0]      obstacle2_type,
  output logic            running
);

  localparam int PW = 10 - CONV;
  localparam logic [PW-1:0] GEN_POS = PW'(GEN_LINE);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pos_q  [2];
  logic [PW-1:0]   pos_d  [2];
  logic [1:0]      type_q [2];
  logic [1:0]      type_d [2];
  logic [7:0]      gap_q, gap_d;
  logic [15:0]     lfsr_q;
  logic            running_q;
  logic            spawn;
  logic [PW-1:0]   speed_ext;

`ifdef OBSTACLE_SPEEDUP_EN
  logic [2:0]      speed_q, speed_d;
  logic [2:0]      cnt_q, cnt_d;
`else
  logic [2:0]      speed_q;
  // Constant scroll speed, never above the configured ceiling.
  assign speed_q = (MAX_SPEED < 3'd1) ? MAX_SPEED : 3'd1;
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] sat_gap(input logic [7:0] base, input logic [5:0] extra);
    logic [8:0] sum;
    sum = {1'b0, base} + {3'b000, extra};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign speed_ext = {{(PW-3){1'b0}}, speed_q};

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    type_d  = type_q;
    gap_d   = gap_q;
    spawn   = 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
    speed_d = speed_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, FROZEN: begin
        if (start) begin
          state_d = RUN;
          for (int i = 0; i < 2; i++) begin
            pos_d[i]  = '0;
            type_d[i] = '0;
          end
          gap_d = MIN_GAP;
`ifdef OBSTACLE_SPEEDUP_EN
          speed_d = 3'd1;
          cnt_d   = 3'd0;
`endif
        end
      end
      RUN: begin
        if (crash) begin
          state_d = FROZEN;
        end else if (game_tick) begin
          // Move first so a slot retired this tick can be refilled this tick.
          for (int i = 0; i < 2; i++) begin
            if (pos_q[i] > speed_ext) begin
              pos_d[i] = pos_q[i] - speed_ext;
            end else begin
              pos_d[i]  = '0;
              type_d[i] = '0;
            end
          end
          if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
          if (gap_q == 8'd0) begin
            if (pos_d[0] == '0) begin
              pos_d[0]  = GEN_POS;
              type_d[0] = lfsr_q[1:0];
              spawn     = 1'b1;
            end else if (pos_d[1] == '0) begin
              pos_d[1]  = GEN_POS;
              type_d[1] = lfsr_q[1:0];
              spawn     = 1'b1;
            end
          end
          if (spawn) begin
            gap_d = sat_gap(MIN_GAP, lfsr_q[7:2]);
`ifdef OBSTACLE_SPEEDUP_EN
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7 && speed_q < MAX_SPEED) speed_d = speed_q + 3'd1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q[0]  <= '0;
      pos_q[1]  <= '0;
      type_q[0] <= '0;
      type_q[1] <= '0;
      gap_q     <= 8'd0;
      lfsr_q    <= 16'hACE1;
      running_q <= 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
      speed_q   <= 3'd1;
      cnt_q     <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      type_q    <= type_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      running_q <= (state_d == RUN);
`ifdef OBSTACLE_SPEEDUP_EN
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign obstacle1_pos  = pos_q[0];
  assign obstacle2_pos  = pos_q[1];
  assign obstacle1_type = type_q[0];
  assign obstacle2_type = type_q[1];
  assign running        = running_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomized bench for obstacle_spawner against a rule-level game model.
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_tick = 1'b0;
  logic       start = 1'b0;
  logic       crash = 1'b0;
  logic [9:0] obstacle1_pos, obstacle2_pos;
  logic [1:0] obstacle1_type, obstacle2_type;
  logic       running;

  obstacle_spawner dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .start(start), .crash(crash),
    .obstacle1_pos(obstacle1_pos), .obstacle2_pos(obstacle2_pos),
    .obstacle1_type(obstacle1_type), .obstacle2_type(obstacle2_type),
    .running(running)
  );

  always #5 clk = ~clk;

`ifdef OBSTACLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model: 0 idle, 1 run, 2 frozen
  int          m_st = 0;
  int          m_pos [2] = '{0, 0};
  int          m_typ [2] = '{0, 0};
  int          m_gap = 0, m_speed = 1, m_cnt = 0, m_spawns = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          old_gap, idx, fb;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_pos = '{0, 0}; m_typ = '{0, 0};
      m_gap = 0; m_speed = 1; m_cnt = 0;
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_pos = '{0, 0}; m_typ = '{0, 0};
        m_gap = 40; m_speed = 1; m_cnt = 0;
      end
    end else if (crash) begin
      m_st = 2;
    end else if (game_tick) begin
      for (int i = 0; i < 2; i++) begin
        if (m_pos[i] > m_speed) m_pos[i] = m_pos[i] - m_speed;
        else begin m_pos[i] = 0; m_typ[i] = 0; end
      end
      old_gap = m_gap;
      if (m_gap > 0) m_gap = m_gap - 1;
      if (old_gap == 0) begin
        idx = (m_pos[0] == 0) ? 0 : (m_pos[1] == 0) ? 1 : -1;
        if (idx >= 0) begin
          m_pos[idx] = 250;
          m_typ[idx] = int'(m_lfsr) % 4;
          m_gap = 40 + ((int'(m_lfsr) / 4) % 64);
          if (m_gap > 255) m_gap = 255;
          m_spawns++;
          if (SPEEDUP) begin
            m_cnt = (m_cnt + 1) % 8;
            if (m_cnt == 0 && m_speed < 4) m_speed++;
          end
        end
      end
    end
    if (rst) m_lfsr = 16'hACE1;
    else begin
      fb = (m_lfsr[15] + m_lfsr[13] + m_lfsr[12] + m_lfsr[10]) % 2;
      m_lfsr = {m_lfsr[14:0], fb[0]};
    end
  end

  function automatic logic [24:0] exp_vec();
    return {10'(m_pos[0]), 10'(m_pos[1]), 2'(m_typ[0]), 2'(m_typ[1]), m_st == 1};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, running};
  endfunction

  task automatic drive(input logic t, input logic s, input logic c, input logic r);
    game_tick = t; start = s; crash = c; rst = r;
    @(posedge clk);
    #1;
    game_tick = 1'b0; start = 1'b0; crash = 1'b0; rst = 1'b0;
  endtask

  task automatic tick();
    repeat ($urandom_range(0, 1)) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    n_checks++;
    if (dut_vec() !== 25'd0) $display("FAIL reset: got %h want 0", dut_vec());
    else n_pass++;
    drive(1, 0, 1, 0);
    n_checks++;
    if (dut_vec() !== exp_vec() || running !== 1'b0)
      $display("FAIL idle_ignores_tick_crash: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_first_spawn();
    repeat ($urandom_range(0, 7)) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    n_checks++;
    if (running !== 1'b1 || obstacle1_pos !== 10'd0 || obstacle2_pos !== 10'd0)
      $display("FAIL start: got %h want running, empty", dut_vec());
    else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_checks++;
      if (obstacle1_pos !== 10'd0 || obstacle2_pos !== 10'd0)
        $display("FAIL no_early_spawn tick %0d: got %0d/%0d want 0/0", k, obstacle1_pos, obstacle2_pos);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (obstacle1_pos !== 10'd250 || obstacle2_pos !== 10'd0 || running !== 1'b1 ||
        dut_vec() !== exp_vec())
      $display("FAIL first_spawn: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_scroll();
    for (int k = 1; k <= 249; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL scroll tick %0d: got %h want %h", k, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (obstacle1_pos !== 10'd1) $display("FAIL scroll_end: got %0d want 1", obstacle1_pos);
    else n_pass++;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec() || (obstacle1_pos !== 10'd250 && obstacle1_pos !== 10'd0) ||
        (obstacle1_pos == 10'd0 && obstacle1_type !== 2'd0))
      $display("FAIL retire: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_full_slots();
    bit blocked;
    for (int k = 0; k < 800; k++) begin
      blocked = (m_gap == 0) && (m_pos[0] != 0) && (m_pos[1] != 0);
      if (blocked && m_pos[0] <= m_speed) begin
        tick();
        n_checks++;
        if (obstacle1_pos !== 10'd250) $display("FAIL reuse_on_retire: got %0d want 250", obstacle1_pos);
        else n_pass++;
      end else begin
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL full_slots tick %0d: got %h want %h", k, dut_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  task automatic test_crash();
    int k = 0;
    while (m_pos[0] != 120 && k < 600) begin tick(); k++; end
    n_checks++;
    if (obstacle1_pos !== 10'd120) begin
      $display("FAIL crash_setup: got %0d want 120 within 600 ticks", obstacle1_pos);
      return;
    end else n_pass++;
    drive(1, 1, 1, 0);
    n_checks++;
    if (obstacle1_pos !== 10'd120 || running !== 1'b0 || dut_vec() !== exp_vec())
      $display("FAIL crash_freeze: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    repeat (5) drive(1, 0, $urandom_range(0, 1), 0);
    n_checks++;
    if (obstacle1_pos !== 10'd120 || dut_vec() !== exp_vec())
      $display("FAIL frozen_hold: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    drive(1, 1, 0, 0);
    n_checks++;
    if (obstacle1_pos !== 10'd0 || obstacle2_pos !== 10'd0 || running !== 1'b1)
      $display("FAIL restart: got %h want running, empty", dut_vec());
    else n_pass++;
    repeat (40) tick();
    n_checks++;
    if (obstacle1_pos !== 10'd0 || obstacle2_pos !== 10'd0)
      $display("FAIL restart_gap: got %0d/%0d want 0/0", obstacle1_pos, obstacle2_pos);
    else n_pass++;
    tick();
    n_checks++;
    if (obstacle1_pos !== 10'd250) $display("FAIL restart_spawn: got %0d want 250", obstacle1_pos);
    else n_pass++;
  endtask

  task automatic test_speedup();
    logic [9:0] p;
    int k = 0;
    while (m_spawns < 30 && k < 6000) begin
      p = obstacle1_pos;
      tick();
      k++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL speedup tick %0d: got %h want %h", k, dut_vec(), exp_vec());
      else n_pass++;
      if (SPEEDUP && m_spawns >= 25 && p > 10'd4) begin
        n_checks++;
        if (obstacle1_pos !== p - 10'd4) $display("FAIL speed_cap: got %0d want %0d", obstacle1_pos, p - 10'd4);
        else n_pass++;
      end
    end
    n_checks++;
    if (m_spawns < 30) $display("FAIL speedup_budget: got %0d spawns want 30", m_spawns);
    else n_pass++;
  endtask

  task automatic test_random();
    logic c = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) c = ~c;
      drive($urandom_range(0, 1), $urandom_range(0, 59) == 0, c, $urandom_range(0, 499) == 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_frozen();
    int k = 0;
    drive(0, 1, 0, 0);
    while ((m_pos[0] == 0 || m_pos[1] == 0) && k < 600) begin tick(); k++; end
    drive(0, 0, 1, 0);
    n_checks++;
    if (obstacle1_pos == 10'd0 || obstacle2_pos == 10'd0 || running !== 1'b0)
      $display("FAIL frozen_setup: got %h want both slots occupied, stopped", dut_vec());
    else n_pass++;
    drive(0, 0, 0, 1);
    n_checks++;
    if (dut_vec() !== 25'd0) $display("FAIL reset_frozen: got %h want 0", dut_vec());
    else n_pass++;
    repeat (60) tick();
    n_checks++;
    if (dut_vec() !== 25'd0) $display("FAIL idle_no_spawn: got %h want 0", dut_vec());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_scroll();
    test_full_slots();
    test_crash();
    test_speedup();
    test_random();
    test_reset_frozen();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Generates and scrolls the two on-screen obstacles of the Dino game and drives the `obstacle1_pos`/`obstacle2_pos` buses consumed by the jump controller and renderer. Once per game tick it moves every active obstacle left, retires obstacles that leave the screen, and spawns new ones at the generation line after a pseudo-random gap. It freezes on crash and restarts cleanly on a start pulse.

## Interface
- `CONV`, 0, low bit index of position buses; positions are `10-CONV` bits wide.
- `GEN_LINE`, 250, spawn x-position in position-bus units; must fit in `10-CONV` bits.
- `MIN_GAP`, 40, minimum ticks between spawns (8-bit).
- `MAX_SPEED`, 4, speed ceiling in units/tick when speedup is compiled in (3-bit).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `game_tick`  in  1  one-cycle pulse per frame; all movement and spawning happens only on these cycles.
- `start`  in  1  one-cycle pulse; starts the game from IDLE or restarts it from FROZEN.
- `crash`  in  1  level from collision logic; freezes the game.
- `obstacle1_pos`, `obstacle2_pos`  out  [9:CONV]  slot x-position; 0 means the slot is empty.
- `obstacle1_type`, `obstacle2_type`  out  2  obstacle sprite select.
- `running`  out  1  high in RUN state.

## Operation
- States: IDLE (after reset), RUN, FROZEN.
- IDLE: slots empty, no movement. `start` -> RUN; clears slots, sets the gap counter to `MIN_GAP` and speed to 1. `crash` is ignored.
- RUN, `crash` high -> FROZEN; nothing moves or spawns on that cycle.
- RUN, `game_tick` high and `crash` low, in this order within the cycle:
  - Move: each active slot with pos > speed gets pos - speed. A slot with pos <= speed becomes empty (pos = 0, type = 0).
  - Gap: if the gap counter is > 0, decrement it.
  - Spawn: if the gap counter was already 0 at the tick and a slot is free after the move step:
    - Load the lowest-index free slot with pos = `GEN_LINE`, type = `lfsr[1:0]`.
    - Reload the gap counter with `MIN_GAP + lfsr[7:2]` (range `MIN_GAP`..`MIN_GAP`+63, 8-bit saturating).
    - A slot freed on this tick may be reused on this tick.
    - If no slot is free, the gap counter holds at 0 and the spawn happens on the first tick that frees a slot.
- FROZEN: positions and types hold. `start` does the same as the IDLE `start` and goes to RUN. `crash` has no further effect.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, seed 16'hACE1 at reset, advances every clock regardless of state.
  - It never reaches all-zero.
  - Because it advances every clock, `start` timing randomizes the sequence.
- Arithmetic: position math is done at width `10-CONV` and never goes negative; an empty slot is exactly 0.

## Timing
- All outputs are registered and update on the edge that samples `game_tick`/`start`/`crash`; latency is 1 cycle.
- Reset values: positions 0, types 0, `running` 0, state IDLE, gap counter 0, speed 1, spawn count 0.
- `rst` overrides everything, including mid-game and FROZEN; IDLE is entered on the next edge.
- Same cycle, RUN: `crash` beats `game_tick` and `start`.
- Same cycle, IDLE/FROZEN: `start` with `game_tick` starts the game but does not move or spawn on that cycle.
- `running` rises the cycle after `start` and falls the cycle after `crash`.

## Configuration
- `OBSTACLE_SPEEDUP_EN` defined:
  - A 3-bit spawn counter increments on each spawn.
  - Each time it wraps (every 8 spawns), speed increments by 1, saturating at `MAX_SPEED`.
  - `start` resets speed to 1 and the count to 0.
- Not defined: speed is constant 1 and the spawn counter is absent.

## Test plan
- Reset, then `start`, then 40 ticks -> no spawn. Tick 41 -> `obstacle1_pos`=250, `obstacle2_pos`=0, `running`=1.
- Slot 1 at 250, speed 1, 249 ticks -> pos 1. Next tick -> pos 0, type 0.
- Both slots occupied, gap counter already 0 -> no spawn. On the tick slot 1 retires -> slot 1 reloads to 250 on that same tick.
- `crash` with slot 1 = 120, same cycle as `game_tick` -> pos stays 120 and `running`=0. `start` -> both pos 0. 40 ticks later -> first spawn.
- With `OBSTACLE_SPEEDUP_EN` -> after 8 spawns obstacles move 2/tick. After 24 spawns, speed = 4 and it holds at 4.
- `rst` asserted in FROZEN with slots at 80/200 -> next cycle positions 0, `running`=0. Ticks without `start` -> no spawns.
